// File: rtl/gpa_fhdo_sched.sv
// gpa_fhdo_sched: round-robin scheduler feeding one pending DAC code per
// gradient channel (X, Y, Z, Z2) into the single GPA-FHDO SPI interface.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   enable_i         allows new grants (an in-flight transfer always finishes)
//   wr_i/wr_ch_i/wr_data_i  per-channel value write (sets pending bit)
//   iface_data_o     32-bit word: [15:0] code, [26:25] channel, rest zero
//   iface_valid_o    one-cycle request pulse to the SPI interface
//   iface_busy_i     busy handshake from the SPI interface
//   pending_o        per-channel pending bits
//   idle_o           IDLE with nothing pending
//   timeout_err_o    sticky: busy never rose after a request
//   overwrite_o      sticky: a pending value was replaced before being sent
//   err_clr_i        clears both sticky flags
//   xfer_cnt_o       completed transfers (wrapping)
module gpa_fhdo_sched #(
  parameter int unsigned TO_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic        wr_i,
  input  logic [1:0]  wr_ch_i,
  input  logic [15:0] wr_data_i,
  output logic [31:0] iface_data_o,
  output logic        iface_valid_o,
  input  logic        iface_busy_i,
  output logic [3:0]  pending_o,
  output logic        idle_o,
  output logic        timeout_err_o,
  output logic        overwrite_o,
  input  logic        err_clr_i,
  output logic [15:0] xfer_cnt_o
);

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 2;
  localparam int unsigned DW  = 16;
  localparam int unsigned XW  = 16;

  // Counter value on the last WAIT_BUSY cycle: 2^TO_W-1 cycles in total.
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   last_grant_q;
  logic [TO_W-1:0] to_cnt_q;
  logic [DW-1:0]   val_q [NCH];

  logic [CW-1:0]   win;
  logic [CW-1:0]   idx;
  logic            found;
  logic            grant;
  logic [NCH-1:0]  wr_set;
  logic [NCH-1:0]  grant_clr;
  logic [NCH-1:0]  pending_nxt;
  logic            ovw_evt;
  logic            to_evt;
  logic            done_evt;

  // Round-robin pick: first pending channel after the last grant.
  always_comb begin
    win   = last_grant_q;
    idx   = last_grant_q;
    found = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      idx = last_grant_q + CW'(i);
      if (!found && pending_o[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Grant, pending update and event decode.
  always_comb begin
    grant       = (state_q == S_IDLE) && enable_i && found && !iface_busy_i;
    wr_set      = wr_i  ? (NCH'(1) << wr_ch_i) : '0;
    grant_clr   = grant ? (NCH'(1) << win)     : '0;
    // A write into the channel being granted keeps it pending with the new value.
    pending_nxt = (pending_o & ~grant_clr) | wr_set;
    ovw_evt     = wr_i && pending_o[wr_ch_i] && !(grant && (win == wr_ch_i));
    to_evt      = (state_q == S_WAIT_BUSY) && !iface_busy_i && (to_cnt_q == TO_LAST);
    done_evt    = (state_q == S_WAIT_DONE) && !iface_busy_i;
  end

  // Per-channel value registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) val_q[i] <= '0;
    end else if (wr_i) begin
      val_q[wr_ch_i] <= wr_data_i;
    end
  end

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      last_grant_q  <= CW'(NCH - 1);
      to_cnt_q      <= '0;
      iface_data_o  <= '0;
      iface_valid_o <= 1'b0;
      pending_o     <= '0;
      idle_o        <= 1'b1;
      timeout_err_o <= 1'b0;
      overwrite_o   <= 1'b0;
      xfer_cnt_o    <= '0;
    end else begin
      iface_valid_o <= 1'b0;
      pending_o     <= pending_nxt;

      case (state_q)
        S_IDLE: begin
          if (grant) begin
            iface_data_o  <= {5'b0, win, 1'b0, 8'b0, val_q[win]};
            iface_valid_o <= 1'b1;
            last_grant_q  <= win;
            to_cnt_q      <= '0;
            state_q       <= S_WAIT_BUSY;
            idle_o        <= 1'b0;
          end else begin
            idle_o        <= (pending_nxt == '0);
          end
        end
        S_WAIT_BUSY: begin
          if (iface_busy_i) begin
            state_q <= S_WAIT_DONE;
            idle_o  <= 1'b0;
          end else if (to_evt) begin
            state_q <= S_IDLE;
            idle_o  <= (pending_nxt == '0);
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
            idle_o   <= 1'b0;
          end
        end
        S_WAIT_DONE: begin
          if (done_evt) begin
            xfer_cnt_o <= xfer_cnt_o + XW'(1);
            state_q    <= S_IDLE;
            idle_o     <= (pending_nxt == '0);
          end else begin
            idle_o     <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          idle_o  <= (pending_nxt == '0);
        end
      endcase

      // Set events take priority over a same-cycle clear.
      if (to_evt)         timeout_err_o <= 1'b1;
      else if (err_clr_i) timeout_err_o <= 1'b0;
      if (ovw_evt)        overwrite_o   <= 1'b1;
      else if (err_clr_i) overwrite_o   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gpa_fhdo_sched.sv
// Directed testbench for gpa_fhdo_sched with a simple SPI busy-handshake model.
module tb_gpa_fhdo_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable_i = 1'b1;
  logic        wr_i = 1'b0;
  logic [1:0]  wr_ch_i = 2'd0;
  logic [15:0] wr_data_i = 16'd0;
  logic [31:0] iface_data_o;
  logic        iface_valid_o;
  logic        iface_busy_i = 1'b0;
  logic [3:0]  pending_o;
  logic        idle_o;
  logic        timeout_err_o;
  logic        overwrite_o;
  logic        err_clr_i = 1'b0;
  logic [15:0] xfer_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Busy model controls and issued-word log.
  logic        busy_auto = 1'b1;
  logic        busy_force = 1'b0;
  int          busy_len = 3;
  int          busy_ctr = 0;
  logic [31:0] log_w [32];
  int          log_n = 0;

  gpa_fhdo_sched #(.TO_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (enable_i),
    .wr_i         (wr_i),
    .wr_ch_i      (wr_ch_i),
    .wr_data_i    (wr_data_i),
    .iface_data_o (iface_data_o),
    .iface_valid_o(iface_valid_o),
    .iface_busy_i (iface_busy_i),
    .pending_o    (pending_o),
    .idle_o       (idle_o),
    .timeout_err_o(timeout_err_o),
    .overwrite_o  (overwrite_o),
    .err_clr_i    (err_clr_i),
    .xfer_cnt_o   (xfer_cnt_o)
  );

  always #5 clk = ~clk;

  // SPI interface model: busy rises right after a valid pulse, lasts busy_len cycles.
  always @(negedge clk) begin
    if (iface_valid_o) begin
      if (log_n < 32) log_w[log_n] = iface_data_o;
      log_n = log_n + 1;
      if (busy_auto) busy_ctr = busy_len;
    end else if (busy_ctr > 0) begin
      busy_ctr = busy_ctr - 1;
    end
    iface_busy_i = busy_force || (busy_ctr > 0);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] ch, input logic [15:0] d);
    wr_i = 1'b1; wr_ch_i = ch; wr_data_i = d;
    @(negedge clk);
    wr_i = 1'b0;
  endtask

  task automatic do_reset();
    int n;
    busy_force = 1'b0; busy_auto = 1'b1; busy_len = 3;
    wr_i = 1'b0; err_clr_i = 1'b0; enable_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    n = 0;
    while (iface_busy_i && n < 200) begin tick(1); n++; end
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic wait_idle(input int max, input string name);
    int n;
    n = 0;
    while (!idle_o && n < max) begin tick(1); n++; end
    n_cmp++;
    if (!idle_o) begin
      n_bad++;
      $display("FAIL %s wait_idle: idle_o=%0b after %0d cycles, required 1", name, idle_o, n);
    end
  endtask

  task automatic test_reset();
    tick(1);
    rst_n = 1'b0;
    tick(2);
    n_cmp++;
    if ({iface_data_o, iface_valid_o, pending_o, idle_o, timeout_err_o, overwrite_o, xfer_cnt_o}
        !== {32'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0}) begin
      n_bad++;
      $display("FAIL reset_vals: data=%h valid=%b pend=%b idle=%b to=%b ow=%b cnt=%0d, required 0/0/0/1/0/0/0",
               iface_data_o, iface_valid_o, pending_o, idle_o, timeout_err_o, overwrite_o, xfer_cnt_o);
    end
    rst_n = 1'b1;
    tick(3);
    n_cmp++;
    if (iface_valid_o !== 1'b0 || idle_o !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_quiet: valid=%b idle=%b, required 0 1", iface_valid_o, idle_o);
    end
  endtask

  task automatic test_single();
    do_reset();
    busy_len = 3;
    wr(2'd2, 16'h1234);
    n_cmp++;
    if (pending_o !== 4'b0100) begin
      n_bad++; $display("FAIL single_pend: pending=%b, required 0100", pending_o);
    end
    tick(1);
    n_cmp++;
    if (iface_valid_o !== 1'b1 || iface_data_o !== 32'h0400_1234) begin
      n_bad++; $display("FAIL single_valid: valid=%b data=%h, required 1 04001234", iface_valid_o, iface_data_o);
    end
    tick(1);
    n_cmp++;
    if (iface_valid_o !== 1'b0 || iface_data_o !== 32'h0400_1234) begin
      n_bad++; $display("FAIL single_pulse: valid=%b data=%h, required 0 04001234", iface_valid_o, iface_data_o);
    end
    wait_idle(50, "single");
    n_cmp++;
    if (xfer_cnt_o !== 16'd1 || pending_o !== 4'b0 || idle_o !== 1'b1) begin
      n_bad++; $display("FAIL single_done: cnt=%0d pend=%b idle=%b, required 1 0000 1", xfer_cnt_o, pending_o, idle_o);
    end
  endtask

  task automatic test_all_channels();
    int base;
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h0000_0001; exp_w[1] = 32'h0200_0002;
    exp_w[2] = 32'h0400_0003; exp_w[3] = 32'h0600_0004;
    do_reset();
    busy_len = 24;
    base = log_n;
    wr(2'd0, 16'h0001);
    wr(2'd1, 16'h0002);
    wr(2'd2, 16'h0003);
    wr(2'd3, 16'h0004);
    wait_idle(400, "all_ch");
    n_cmp++;
    if (log_n - base !== 4) begin
      n_bad++; $display("FAIL all_ch_count: issued=%0d, required 4", log_n - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (log_w[base+i] !== exp_w[i]) begin
          n_bad++; $display("FAIL all_ch_word%0d: got %h, required %h", i, log_w[base+i], exp_w[i]);
        end
      end
    end
    n_cmp++;
    if (xfer_cnt_o !== 16'd4) begin
      n_bad++; $display("FAIL all_ch_cnt: cnt=%0d, required 4", xfer_cnt_o);
    end
  endtask

  task automatic test_round_robin();
    int base;
    do_reset();
    busy_len = 3;
    wr(2'd1, 16'h1111);
    wait_idle(50, "rr_prep");
    busy_force = 1'b1;
    tick(1);
    wr(2'd0, 16'hA000);
    wr(2'd3, 16'hD000);
    tick(1);
    n_cmp++;
    if (pending_o !== 4'b1001 || iface_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL rr_hold: pend=%b valid=%b, required 1001 0", pending_o, iface_valid_o);
    end
    base = log_n;
    busy_force = 1'b0;
    wait_idle(100, "rr");
    n_cmp++;
    if (log_n - base !== 2 || log_w[base] !== 32'h0600_D000 || log_w[base+1] !== 32'h0000_A000) begin
      n_bad++;
      $display("FAIL rr_order: n=%0d first=%h second=%h, required 2 0600d000 0000a000",
               log_n - base, log_w[base], log_w[base+1]);
    end
  endtask

  task automatic test_overwrite();
    int base;
    do_reset();
    busy_force = 1'b1;
    tick(1);
    wr(2'd1, 16'hAAAA);
    n_cmp++;
    if (overwrite_o !== 1'b0) begin
      n_bad++; $display("FAIL ow_first: overwrite=%b, required 0", overwrite_o);
    end
    wr(2'd1, 16'hBBBB);
    n_cmp++;
    if (overwrite_o !== 1'b1) begin
      n_bad++; $display("FAIL ow_set: overwrite=%b, required 1", overwrite_o);
    end
    base = log_n;
    busy_force = 1'b0;
    wait_idle(100, "ow");
    n_cmp++;
    if (log_n - base !== 1 || log_w[base] !== 32'h0200_BBBB) begin
      n_bad++; $display("FAIL ow_sent: n=%0d word=%h, required 1 0200bbbb", log_n - base, log_w[base]);
    end
    err_clr_i = 1'b1;
    tick(1);
    err_clr_i = 1'b0;
    n_cmp++;
    if (overwrite_o !== 1'b0 || xfer_cnt_o !== 16'd1) begin
      n_bad++; $display("FAIL ow_clr: overwrite=%b cnt=%0d, required 0 1", overwrite_o, xfer_cnt_o);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    busy_auto = 1'b0;
    wr(2'd0, 16'h5555);
    tick(1);
    n_cmp++;
    if (iface_valid_o !== 1'b1) begin
      n_bad++; $display("FAIL to_valid: valid=%b, required 1", iface_valid_o);
    end
    n = 0;
    while (!timeout_err_o && n < 400) begin tick(1); n++; end
    n_cmp++;
    if (n !== 255) begin
      n_bad++; $display("FAIL to_latency: cycles=%0d, required 255", n);
    end
    n_cmp++;
    if (timeout_err_o !== 1'b1 || xfer_cnt_o !== 16'd0 || pending_o !== 4'b0 || idle_o !== 1'b1) begin
      n_bad++;
      $display("FAIL to_state: to=%b cnt=%0d pend=%b idle=%b, required 1 0 0000 1",
               timeout_err_o, xfer_cnt_o, pending_o, idle_o);
    end
    err_clr_i = 1'b1;
    tick(1);
    err_clr_i = 1'b0;
    n_cmp++;
    if (timeout_err_o !== 1'b0) begin
      n_bad++; $display("FAIL to_clr: to=%b, required 0", timeout_err_o);
    end
    busy_auto = 1'b1;
  endtask

  task automatic test_enable();
    logic seen;
    do_reset();
    enable_i = 1'b0;
    wr(2'd3, 16'h0BEE);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (iface_valid_o) seen = 1'b1;
      tick(1);
    end
    n_cmp++;
    if (seen !== 1'b0 || pending_o !== 4'b1000 || idle_o !== 1'b0) begin
      n_bad++; $display("FAIL en_block: valid_seen=%b pend=%b idle=%b, required 0 1000 0", seen, pending_o, idle_o);
    end
    enable_i = 1'b1;
    tick(1);
    n_cmp++;
    if (iface_valid_o !== 1'b1 || iface_data_o !== 32'h0600_0BEE) begin
      n_bad++; $display("FAIL en_grant: valid=%b data=%h, required 1 06000bee", iface_valid_o, iface_data_o);
    end
    wait_idle(50, "en");
  endtask

  task automatic test_reset_mid();
    int n;
    logic seen;
    do_reset();
    busy_len = 40;
    wr(2'd1, 16'h0321);
    tick(6);
    rst_n = 1'b0;
    tick(1);
    n_cmp++;
    if ({iface_data_o, iface_valid_o, pending_o, idle_o, timeout_err_o, overwrite_o, xfer_cnt_o}
        !== {32'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0} || iface_busy_i !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_vals: data=%h valid=%b pend=%b idle=%b cnt=%0d busy=%b, required 0 0 0 1 0 busy1",
               iface_data_o, iface_valid_o, pending_o, idle_o, xfer_cnt_o, iface_busy_i);
    end
    rst_n = 1'b1;
    wr(2'd2, 16'h0777);
    n_cmp++;
    if (pending_o !== 4'b0100) begin
      n_bad++; $display("FAIL rst_mid_pend: pend=%b, required 0100", pending_o);
    end
    seen = 1'b0;
    n = 0;
    while (iface_busy_i && n < 100) begin
      if (iface_valid_o) seen = 1'b1;
      tick(1); n++;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_hold: valid during busy=%b, required 0", seen);
    end
    n = 0;
    while (!iface_valid_o && n < 5) begin tick(1); n++; end
    n_cmp++;
    if (iface_valid_o !== 1'b1 || iface_data_o !== 32'h0400_0777) begin
      n_bad++; $display("FAIL rst_mid_issue: valid=%b data=%h, required 1 04000777", iface_valid_o, iface_data_o);
    end
    wait_idle(100, "rst_mid");
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_channels();
    test_round_robin();
    test_overwrite();
    test_timeout();
    test_enable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
